// File: rtl/cp0_intc_if.sv
// cp0_intc_if: MEM-stage pipeline <-> CP0 signal bundle (master = pipeline, slave = CP0)
interface cp0_intc_if #(
   parameter int HW_IRQ = 6
);
   logic              valid;
   logic              we;
   logic [4:0]        addr;
   logic [31:0]       wdata;
   logic [31:0]       rdata;
   logic [31:0]       vpc;
   logic              bd_in;
   logic [4:0]        exccode_in;
   logic              eret;
   logic [HW_IRQ-1:0] hwint;
   logic              req;
   logic [31:0]       epc_out;
   logic              timer_irq;
   modport master (
      output valid, we, addr, wdata, vpc, bd_in, exccode_in, eret, hwint,
      input  rdata, req, epc_out, timer_irq
   );
   modport slave (
      input  valid, we, addr, wdata, vpc, bd_in, exccode_in, eret, hwint,
      output rdata, req, epc_out, timer_irq
   );
endinterface

// File: rtl/cp0_intc.sv
// cp0_intc: MIPS CP0 (SR/Cause/EPC/PRId, Count/Compare) with exception/interrupt arbitration
module cp0_intc #(
   parameter int          HW_IRQ   = 6,
   parameter bit          TIMER_EN = 1'b1,
   parameter logic [31:0] PRID     = 32'h0000_0000
) (
   input logic       clk,
   input logic       reset,
   cp0_intc_if.slave bus
);
   logic [5:0]  im_q, im_d, ip_q, ip_d, hw_pad;
   logic        exl_q, exl_d, ie_q, ie_d, bd_q, bd_d, ti_q, ti_d;
   logic [4:0]  exc_q, exc_d;
   logic [31:0] epc_q, epc_d, count_q, count_d, compare_q, compare_d, count_inc, rdata;
   logic        int_req, exc_req, req, wr, wr_sr, wr_epc, wr_count, wr_compare;
   always_comb begin
      hw_pad = '0;
      hw_pad[HW_IRQ-1:0] = bus.hwint;
   end
   assign int_req    = bus.valid & ie_q & ~exl_q & (|(im_q & ip_q));
   assign exc_req    = bus.valid & ~exl_q & (bus.exccode_in != 5'd0);
   assign req        = reset & (int_req | exc_req);
   assign wr         = bus.we & ~req;
   assign wr_sr      = wr & (bus.addr == 5'd12);
   assign wr_epc     = wr & (bus.addr == 5'd14);
   assign wr_count   = wr & (bus.addr == 5'd9);
   assign wr_compare = wr & (bus.addr == 5'd11);
   assign count_inc  = count_q + 32'd1;
   always_comb begin
      ip_d      = hw_pad | {TIMER_EN & ti_q, 5'd0};
      im_d      = wr_sr ? bus.wdata[15:10] : im_q;
      ie_d      = wr_sr ? bus.wdata[0] : ie_q;
      exl_d     = req ? 1'b1 : (bus.eret ? 1'b0 : (wr_sr ? bus.wdata[1] : exl_q));
      bd_d      = req ? bus.bd_in : bd_q;
      exc_d     = req ? (int_req ? 5'd0 : bus.exccode_in) : exc_q;
      epc_d     = req ? (bus.bd_in ? bus.vpc - 32'd4 : bus.vpc) : (wr_epc ? bus.wdata : epc_q);
      count_d   = !TIMER_EN ? 32'd0 : (wr_count ? bus.wdata : count_inc);
      compare_d = !TIMER_EN ? 32'd0 : (wr_compare ? bus.wdata : compare_q);
      // TI is sticky; only a Compare write clears it
      ti_d      = TIMER_EN && !wr_compare && (ti_q || (!wr_count && count_inc == compare_q));
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         im_q      <= '0;
         ip_q      <= '0;
         exl_q     <= 1'b0;
         ie_q      <= 1'b0;
         bd_q      <= 1'b0;
         ti_q      <= 1'b0;
         exc_q     <= '0;
         epc_q     <= '0;
         count_q   <= '0;
         compare_q <= '0;
      end else begin
         im_q      <= im_d;
         ip_q      <= ip_d;
         exl_q     <= exl_d;
         ie_q      <= ie_d;
         bd_q      <= bd_d;
         ti_q      <= ti_d;
         exc_q     <= exc_d;
         epc_q     <= epc_d;
         count_q   <= count_d;
         compare_q <= compare_d;
      end
   end
   always_comb begin
      case (bus.addr)
         5'd9:    rdata = count_q;
         5'd11:   rdata = compare_q;
         5'd12:   rdata = {16'd0, im_q, 8'd0, exl_q, ie_q};
         5'd13:   rdata = {bd_q, ti_q, 14'd0, ip_q, 3'd0, exc_q, 2'd0};
         5'd14:   rdata = epc_q;
         5'd15:   rdata = PRID;
         default: rdata = 32'd0;
      endcase
   end
   assign bus.rdata     = rdata;
   assign bus.req       = req;
   assign bus.timer_irq = ti_q;
   // same-cycle mtc0 EPC bypass so an eret in ID sees the new return address
   assign bus.epc_out   = (reset & wr_epc) ? bus.wdata : epc_q;
endmodule

// File: tb/tb_cp0_intc.sv
// tb_cp0_intc: directed scenario tests for cp0_intc
module tb_cp0_intc;
   logic        clk = 1'b0;
   logic        reset;
   int          total = 0;
   int          bad = 0;
   logic [31:0] c;
   localparam logic [31:0] PRID_V = 32'h0001_9300;
   cp0_intc_if #(.HW_IRQ(6)) bus ();
   cp0_intc #(.HW_IRQ(6), .TIMER_EN(1'b1), .PRID(PRID_V)) dut (.clk(clk), .reset(reset), .bus(bus));
   always #5 clk = ~clk;
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic rd(input logic [4:0] a);
      bus.we = 1'b0;
      bus.addr = a;
      #1;
   endtask
   task automatic test_reset();
      reset = 1'b0;
      bus.valid = 0; bus.we = 0; bus.addr = 0; bus.wdata = 0; bus.vpc = 0;
      bus.bd_in = 0; bus.exccode_in = 0; bus.eret = 0; bus.hwint = 0;
      tick(); tick();
      rd(5'd12); total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL rst_sr got=%h exp=0", bus.rdata); end
      rd(5'd13); total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL rst_cause got=%h exp=0", bus.rdata); end
      rd(5'd14); total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL rst_epc got=%h exp=0", bus.rdata); end
      rd(5'd15); total++; if (bus.rdata !== PRID_V) begin bad++; $display("FAIL rst_prid got=%h exp=%h", bus.rdata, PRID_V); end
      total++; if (bus.req !== 1'b0 || bus.epc_out !== 32'd0 || bus.timer_irq !== 1'b0) begin
         bad++; $display("FAIL rst_outs req=%b epc_out=%h ti=%b exp 0/0/0", bus.req, bus.epc_out, bus.timer_irq);
      end
      reset = 1'b1;
      for (int i = 1; i <= 3; i++) begin
         tick();
         rd(5'd9); total++; if (bus.rdata !== 32'(i)) begin bad++; $display("FAIL count_run got=%0d exp=%0d", bus.rdata, i); end
      end
   endtask
   task automatic test_exception();
      bus.valid = 1; bus.exccode_in = 5'd4; bus.vpc = 32'h3010; bus.bd_in = 1;
      #1; total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL exc_req got=%b exp=1", bus.req); end
      tick();
      bus.valid = 0; bus.exccode_in = 0; bus.bd_in = 0;
      rd(5'd14); total++; if (bus.rdata !== 32'h300C) begin bad++; $display("FAIL exc_epc got=%h exp=300c", bus.rdata); end
      rd(5'd13); total++; if (bus.rdata !== 32'h8000_0010) begin bad++; $display("FAIL exc_cause got=%h exp=80000010", bus.rdata); end
      rd(5'd12); total++; if (bus.rdata !== 32'h2) begin bad++; $display("FAIL exc_sr got=%h exp=2", bus.rdata); end
      bus.valid = 1; bus.exccode_in = 5'd6;
      #1; total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL exc_nested got=%b exp=0", bus.req); end
      tick();
      bus.valid = 0; bus.exccode_in = 0;
      rd(5'd13); total++; if (bus.rdata !== 32'h8000_0010) begin bad++; $display("FAIL exc_dropped got=%h exp=80000010", bus.rdata); end
   endtask
   task automatic test_interrupt();
      bus.we = 1; bus.addr = 5'd12; bus.wdata = 32'h0000_0401;
      tick();
      bus.we = 0; bus.hwint = 6'b000001; bus.valid = 1; bus.vpc = 32'h3200;
      #1; total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL irq_early got=%b exp=0", bus.req); end
      tick();
      bus.exccode_in = 5'd10;
      #1; total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL irq_req got=%b exp=1", bus.req); end
      tick();
      bus.exccode_in = 0;
      #1; total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL irq_masked got=%b exp=0", bus.req); end
      bus.valid = 0;
      rd(5'd13); total++; if (bus.rdata !== 32'h0000_0400) begin bad++; $display("FAIL irq_cause got=%h exp=00000400", bus.rdata); end
      rd(5'd14); total++; if (bus.rdata !== 32'h3200) begin bad++; $display("FAIL irq_epc got=%h exp=3200", bus.rdata); end
   endtask
   task automatic test_handler();
      bus.we = 1; bus.addr = 5'd14; bus.wdata = 32'h3100;
      #1; total++; if (bus.epc_out !== 32'h3100) begin bad++; $display("FAIL epc_bypass got=%h exp=3100", bus.epc_out); end
      tick();
      rd(5'd14); total++; if (bus.rdata !== 32'h3100) begin bad++; $display("FAIL epc_written got=%h exp=3100", bus.rdata); end
      bus.eret = 1; bus.valid = 1; bus.vpc = 32'h3400;
      #1; total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL eret_cycle got=%b exp=0", bus.req); end
      tick();
      bus.eret = 0; bus.valid = 0;
      #1; total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL bubble_block got=%b exp=0", bus.req); end
      bus.valid = 1;
      #1; total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL eret_reraise got=%b exp=1", bus.req); end
      tick();
      bus.valid = 0; bus.hwint = 0;
      rd(5'd14); total++; if (bus.rdata !== 32'h3400) begin bad++; $display("FAIL reraise_epc got=%h exp=3400", bus.rdata); end
   endtask
   task automatic test_timer();
      bus.we = 1; bus.addr = 5'd12; bus.wdata = 32'h0000_8001;
      tick();
      rd(5'd9); c = bus.rdata;
      bus.we = 1; bus.addr = 5'd11; bus.wdata = c + 32'd5; bus.vpc = 32'h3300;
      tick(); bus.we = 0;
      tick(); tick(); tick();
      total++; if (bus.timer_irq !== 1'b0) begin bad++; $display("FAIL ti_early got=%b exp=0", bus.timer_irq); end
      tick();
      total++; if (bus.timer_irq !== 1'b1) begin bad++; $display("FAIL ti_rise got=%b exp=1", bus.timer_irq); end
      bus.valid = 1;
      #1; total++; if (bus.req !== 1'b0) begin bad++; $display("FAIL ti_req_early got=%b exp=0", bus.req); end
      tick();
      total++; if (bus.req !== 1'b1) begin bad++; $display("FAIL ti_req got=%b exp=1", bus.req); end
      tick();
      bus.valid = 0;
      rd(5'd13); total++; if (bus.rdata !== 32'h4000_8000) begin bad++; $display("FAIL ti_cause got=%h exp=40008000", bus.rdata); end
      bus.we = 1; bus.addr = 5'd11; bus.wdata = 32'd0;
      tick(); bus.we = 0;
      #1; total++; if (bus.timer_irq !== 1'b0) begin bad++; $display("FAIL ti_clear got=%b exp=0", bus.timer_irq); end
   endtask
   task automatic test_wrap();
      bus.we = 1; bus.addr = 5'd9; bus.wdata = 32'hFFFF_FFFD;
      tick(); bus.we = 0;
      tick(); tick();
      rd(5'd9); total++; if (bus.rdata !== 32'hFFFF_FFFF) begin bad++; $display("FAIL wrap_pre got=%h exp=ffffffff", bus.rdata); end
      total++; if (bus.timer_irq !== 1'b0) begin bad++; $display("FAIL wrap_ti_early got=%b exp=0", bus.timer_irq); end
      tick();
      rd(5'd9); total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL wrap_zero got=%h exp=0", bus.rdata); end
      total++; if (bus.timer_irq !== 1'b1) begin bad++; $display("FAIL wrap_ti got=%b exp=1", bus.timer_irq); end
   endtask
   task automatic test_async_reset();
      tick();
      rd(5'd12); total++; if (bus.rdata !== 32'h0000_8003) begin bad++; $display("FAIL pre_rst_sr got=%h exp=00008003", bus.rdata); end
      reset = 1'b0;
      #1; total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL async_sr got=%h exp=0", bus.rdata); end
      rd(5'd14); total++; if (bus.rdata !== 32'd0) begin bad++; $display("FAIL async_epc got=%h exp=0", bus.rdata); end
      bus.valid = 1; bus.exccode_in = 5'd4;
      #1; total++; if (bus.req !== 1'b0 || bus.timer_irq !== 1'b0) begin
         bad++; $display("FAIL async_outs req=%b ti=%b exp 0/0", bus.req, bus.timer_irq);
      end
      bus.valid = 0; bus.exccode_in = 0;
      tick();
      reset = 1'b1;
      tick();
      rd(5'd9); total++; if (bus.rdata !== 32'd1) begin bad++; $display("FAIL restart_count got=%0d exp=1", bus.rdata); end
   endtask
   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end
   initial begin
      test_reset();
      test_exception();
      test_interrupt();
      test_handler();
      test_timer();
      test_wrap();
      test_async_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
